// File: rtl/serial_full_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues requests and the slave returns results.
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  diff, bout, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, busy, done
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow,
// producing diff = a - b - bin LSB first under a start/busy/done handshake.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_full_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic br);
        return (~x & y) | (~(x ^ y) & br);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_bit_s;
    logic             br_next_s;
    logic [WIDTH:0]   res_ext_s;
    logic [WIDTH-1:0] res_shift_s;

    // Full-subtractor cell on the current LSBs; result enters at the MSB.
    always_comb begin
        d_bit_s     = fs_diff(a_sr_q[0], b_sr_q[0], br_q);
        br_next_s   = fs_borrow(a_sr_q[0], b_sr_q[0], br_q);
        res_ext_s   = {d_bit_s, res_q};
        res_shift_s = res_ext_s[WIDTH:1];
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = {CW{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = br_next_s;
                res_d  = res_shift_s;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    diff_d  = res_shift_s;
                    bout_d  = br_next_s;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy/done are registered so they line up with the state they describe
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
